handshake_rr_concentrator: RTL and testbench
============================================

Name: handshake_rr_concentrator

Overview:
- Single-clock, parametrised multi-channel successor to the single-word request/capable handshake.
- CHANNELS independent producers each present a WIDTH-bit word with an inrequest/incapable handshake.
- A round-robin arbiter admits at most one word per cycle into a DEPTH-entry FIFO tagged with its source channel.
- The consumer drains the FIFO through an outvalid/outaccept handshake. The block sits between producer logic and a shared downstream sink.

Parameters:
- WIDTH, 32, data word width in bits.
- CHANNELS, 4, number of input channels; legal range 2..16.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
- datain  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]; must be held stable while inrequest[i]=1.
- inrequest  in  CHANNELS  per-channel request level; held high until accepted.
- incapable  out  CHANNELS  per-channel accept strobe, one-hot or zero; the word is taken on the edge where inrequest[i]&incapable[i].
- dataout  out  WIDTH  FIFO head data.
- outchannel  out  clog2(CHANNELS)  source channel of the FIFO head.
- outvalid  out  1  FIFO non-empty.
- outaccept  in  1  consumer takes the head on the edge where outvalid&outaccept.
- count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, outvalid=0, dataout=0, outchannel=0.
  - All FIFO storage cleared to 0.
  - Read and write pointers =0.
  - Round-robin last-grant pointer = CHANNELS-1, so channel 0 has first priority.
  - incapable=0 while reset is low.
- Arbitration (combinational from inrequest, the last-grant pointer and full):
  - full = (count==DEPTH).
  - If !full, search channels starting at last+1 mod CHANNELS; the first channel with inrequest high is granted and its incapable bit is raised.
  - If full or no requests, incapable=0.
  - At most one incapable bit is high in any cycle.
- Push: on a granted edge, write {channel index, word} at the write pointer, advance the write pointer (wraps mod DEPTH), and set last-grant = granted channel.
- Pop: on an edge where outvalid&outaccept, advance the read pointer (wraps mod DEPTH).
- Head outputs: dataout and outchannel come from the entry at the read pointer. outvalid = (count!=0).
- Latency: a word accepted at edge N into an empty FIFO is visible on dataout with outvalid=1 after edge N, i.e. one cycle.
- Occupancy:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Full: there is no same-cycle pass-through. While count==DEPTH, no grant is issued, even if outaccept=1 that cycle. Granting resumes the cycle after count drops.
- Empty: outaccept is ignored while outvalid=0; pointers and count do not move.
- Fairness: each continuously requesting channel is granted within CHANNELS grant cycles. A channel that drops inrequest before being granted loses nothing; no state is kept for it.
- Producer rule: the producer must not change datain[i] while inrequest[i]=1 and incapable[i]=0. After an accept, the producer may present the next word the following cycle.
- Reset mid-operation: all queued words are discarded, outvalid falls asynchronously, and arbitration restarts from channel 0.
- Ordering: FIFO order equals grant order; a single channel's words are never reordered.

Decomposition:
- Shared package/header holds:
  - localparams CHW=clog2(CHANNELS) and AW=clog2(DEPTH);
  - the entry layout {CHW-bit channel, WIDTH-bit data};
  - a clog2 function.
- One sub-module: handshake_rr_arbiter, parameterised by CHANNELS.
  - Inputs: request vector, enable (=!full), update strobe.
  - Outputs: one-hot grant and granted index.
  - Owns the last-grant register.
- FIFO storage and pointers stay in the top module.

Test Plan:
- Reset then single word: CHANNELS=4; after reset release, inrequest=4'b0100 with channel 2 word 32'h0000_00AA → incapable=4'b0100 for exactly one cycle; next cycle outvalid=1, dataout=32'hAA, outchannel=2, count=1.
- Round-robin fairness: all four channels request continuously, outaccept=1 → grant order 0,1,2,3,0,1; each channel's incapable is high once per four cycles; count stays ≤1.
- Fill to full: DEPTH=4, outaccept=0, channels 0 and 1 request with incrementing data 2,4,6,8 → four accepts, count=4, incapable=0 thereafter. Raise outaccept for one cycle → count=3, and a grant occurs the following cycle.
- Simultaneous push/pop at count=2 → count stays 2; FIFO output order matches grant order; pointer wrap is verified over 10 words.
- Asynchronous reset mid-stream: drop reset between edges with count=3 → outvalid=0, count=0, dataout=0 immediately. After release, the first grant goes to the lowest requesting channel.
- Empty accept: outaccept=1 with no requests for 5 cycles → outvalid stays 0, count stays 0, no pointer movement.

Source files
------------

// File: rtl/handshake_rr_concentrator_pkg.sv
// Shared helpers and default geometry for the round-robin handshake concentrator.
// A FIFO entry is packed as {channel index, data word}, channel in the upper bits.
package handshake_rr_concentrator_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_CHW      = clog2(DEF_CHANNELS);
    localparam int DEF_AW       = clog2(DEF_DEPTH);
    localparam int DEF_EW       = DEF_CHW + DEF_WIDTH;

endpackage

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted channel.
// The last-grant register moves only when the caller strobes update.
module handshake_rr_arbiter
    import handshake_rr_concentrator_pkg::*;
#(
    parameter int CHANNELS = 4,
    localparam int CHW = clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] req,
    input  logic                enable,
    input  logic                update,
    output logic [CHANNELS-1:0] grant,
    output logic [CHW-1:0]      grant_idx
);

    logic [CHW-1:0] last_q;
    logic [CHW-1:0] last_d;
    logic [CHW-1:0] idx_v;
    logic           found;
    int             idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        idx_v     = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx   = (int'(last_q) + k) % CHANNELS;
            idx_v = CHW'(idx);
            if (enable && !found && req[idx_v]) begin
                found        = 1'b1;
                grant[idx_v] = 1'b1;
                grant_idx    = idx_v;
            end
        end
        last_d = last_q;
        if (update && found) begin
            last_d = grant_idx;
        end
    end

    // Reset to the top channel so channel 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= CHW'(CHANNELS - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/handshake_rr_concentrator.sv
// Multi-channel inrequest/incapable producers merged by a round-robin arbiter
// into a channel-tagged FIFO drained through outvalid/outaccept.
module handshake_rr_concentrator
    import handshake_rr_concentrator_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4,
    localparam int CHW = clog2(CHANNELS),
    localparam int AW  = clog2(DEPTH),
    localparam int EW  = CHW + WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] datain,
    input  logic [CHANNELS-1:0]       inrequest,
    output logic [CHANNELS-1:0]       incapable,
    output logic [WIDTH-1:0]          dataout,
    output logic [CHW-1:0]            outchannel,
    output logic                      outvalid,
    input  logic                      outaccept,
    output logic [AW:0]               count
);

    logic [EW-1:0]       mem_q [DEPTH];
    logic [EW-1:0]       mem_d [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic [WIDTH-1:0]    chan_word [CHANNELS];
    logic [CHANNELS-1:0] grant;
    logic [CHW-1:0]      grant_idx;
    logic                full;
    logic                push;
    logic                pop;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
        assign chan_word[g] = datain[g*WIDTH +: WIDTH];
    end

    assign full = (count_q == (AW+1)'(DEPTH));

    // Gating with reset keeps incapable low for the whole time reset is held.
    handshake_rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arbiter (
        .clk       (clock),
        .rst_n     (reset),
        .req       (inrequest),
        .enable    (!full && reset),
        .update    (push),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign push       = |grant;
    assign pop        = outvalid && outaccept;
    assign incapable  = grant;
    assign outvalid   = (count_q != '0);
    assign count      = count_q;
    assign dataout    = mem_q[rd_ptr_q][WIDTH-1:0];
    assign outchannel = mem_q[rd_ptr_q][EW-1:WIDTH];

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {grant_idx, chan_word[grant_idx]};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_handshake_rr_concentrator.sv
// Bench for handshake_rr_concentrator: directed scenarios plus a random phase,
// checked against a queue-based reference of arbitration, occupancy and order.
module tb_handshake_rr_concentrator;

    localparam int W   = 32;
    localparam int CH  = 4;
    localparam int D   = 4;
    localparam int CHW = 2;
    localparam int AW  = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [CH*W-1:0] datain = '0;
    logic [CH-1:0]   inrequest = '0;
    logic [CH-1:0]   incapable;
    logic [W-1:0]    dataout;
    logic [CHW-1:0]  outchannel;
    logic            outvalid;
    logic            outaccept = 1'b0;
    logic [AW:0]     count;

    handshake_rr_concentrator #(
        .WIDTH    (W),
        .CHANNELS (CH),
        .DEPTH    (D)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .datain     (datain),
        .inrequest  (inrequest),
        .incapable  (incapable),
        .dataout    (dataout),
        .outchannel (outchannel),
        .outvalid   (outvalid),
        .outaccept  (outaccept),
        .count      (count)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [CHW+W-1:0] exp_q[$];
    int mcount = 0;
    int mlast  = CH - 1;
    int next_val = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: rotating priority from the last grant, no grant while full.
    always @(negedge clock) begin
        logic [CH-1:0] eg;
        int gc;
        int c;
        if (!reset) begin
            mcount = 0;
            mlast  = CH - 1;
            exp_q.delete();
            check("reset_incapable", {60'd0, incapable}, 64'd0);
        end else begin
            eg = '0;
            gc = -1;
            if (mcount < D) begin
                for (int k = 1; k <= CH; k++) begin
                    c = (mlast + k) % CH;
                    if (gc < 0 && inrequest[c]) gc = c;
                end
            end
            if (gc >= 0) eg[gc] = 1'b1;
            check("incapable", {60'd0, incapable}, {60'd0, eg});
            check("count", {61'd0, count}, 64'(mcount));
            check("outvalid", {63'd0, outvalid}, {63'd0, mcount != 0});
            if (gc >= 0) begin
                exp_q.push_back({CHW'(gc), datain[gc*W +: W]});
                mlast = gc;
            end
            mcount = mcount + ((gc >= 0) ? 1 : 0) - ((mcount != 0 && outaccept) ? 1 : 0);
        end
    end

    // Monitor: every consumed head must match the oldest expected entry.
    always @(negedge clock) begin
        logic [CHW+W-1:0] e;
        if (reset && outvalid && outaccept) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("dataout", {32'd0, dataout}, {32'd0, e[W-1:0]});
                check("outchannel", {62'd0, outchannel}, {62'd0, e[CHW+W-1:W]});
            end
        end
    end

    // One cycle of producer behaviour; policy 0 = no new requests,
    // 1 = random raise with pct, 2 = incrementing-by-2 data while next_val <= 8.
    task automatic step(input int policy, input int pct, input logic [CH-1:0] mask);
        logic [CH-1:0] acc;
        @(negedge clock);
        acc = inrequest & incapable;
        @(posedge clock);
        #1;
        for (int i = 0; i < CH; i++) begin
            if (acc[i]) inrequest[i] = 1'b0;
            if (!inrequest[i] && mask[i]) begin
                if (policy == 1 && $urandom_range(0, 99) < pct) begin
                    inrequest[i] = 1'b1;
                    datain[i*W +: W] = $urandom;
                end else if (policy == 2 && next_val <= 8) begin
                    inrequest[i] = 1'b1;
                    datain[i*W +: W] = next_val;
                    next_val += 2;
                end
            end
        end
        #1;
    endtask

    // Reset asserted between edges; outputs must clear immediately.
    task automatic do_reset(input string name);
        @(posedge clock);
        #3;
        reset = 1'b0;
        inrequest = '0;
        #1;
        check({name, "_outvalid"}, {63'd0, outvalid}, 64'd0);
        check({name, "_count"}, {61'd0, count}, 64'd0);
        check({name, "_dataout"}, {32'd0, dataout}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic drain(input int budget);
        outaccept = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (count == 0 && inrequest == '0) break;
            step(0, 0, '0);
        end
        check("drain_count", {61'd0, count}, 64'd0);
        outaccept = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("rst_count", {61'd0, count}, 64'd0);
        check("rst_outvalid", {63'd0, outvalid}, 64'd0);
        check("rst_dataout", {32'd0, dataout}, 64'd0);
        check("rst_outchannel", {62'd0, outchannel}, 64'd0);

        // Single word from channel 2
        inrequest = 4'b0100;
        datain[2*W +: W] = 32'h0000_00AA;
        #1;
        check("t1_grant", {60'd0, incapable}, 64'h4);
        step(0, 0, '0);
        check("t1_grant_once", {60'd0, incapable}, 64'd0);
        check("t1_outvalid", {63'd0, outvalid}, 64'd1);
        check("t1_dataout", {32'd0, dataout}, 64'hAA);
        check("t1_outchannel", {62'd0, outchannel}, 64'd2);
        check("t1_count", {61'd0, count}, 64'd1);
        drain(10);

        // Round-robin with all channels requesting continuously
        do_reset("rr_rst");
        outaccept = 1'b1;
        for (int i = 0; i < CH; i++) datain[i*W +: W] = $urandom;
        inrequest = 4'hF;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("rr_order", {60'd0, incapable}, 64'(1 << (k % CH)));
            check("rr_count_le1", {63'd0, count <= 1}, 64'd1);
            step(1, 100, 4'hF);
        end
        inrequest = '0;
        drain(10);

        // Fill to full with data 2,4,6,8 from channels 0 and 1
        do_reset("fill_rst");
        outaccept = 1'b0;
        inrequest = 4'b0011;
        datain[0 +: W] = 2;
        datain[W +: W] = 4;
        next_val = 6;
        repeat (4) step(2, 0, 4'b0011);
        check("fill_count", {61'd0, count}, 64'd4);
        inrequest[2] = 1'b1;
        datain[2*W +: W] = $urandom;
        #1;
        repeat (2) begin
            check("full_no_grant", {60'd0, incapable}, 64'd0);
            step(0, 0, '0);
        end
        outaccept = 1'b1;
        #1;
        check("full_accept_no_grant", {60'd0, incapable}, 64'd0);
        step(0, 0, '0);
        outaccept = 1'b0;
        #1;
        check("after_pop_count", {61'd0, count}, 64'd3);
        check("after_pop_grant", {60'd0, incapable}, 64'h4);
        step(0, 0, '0);
        drain(20);

        // Simultaneous push/pop at count 2, wrapping over 10+ words
        do_reset("pp_rst");
        inrequest[0] = 1'b1;
        datain[0 +: W] = $urandom;
        repeat (2) step(1, 100, 4'b0001);
        outaccept = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("pp_count", {61'd0, count}, 64'd2);
            step(1, 100, 4'b0001);
        end
        drain(20);

        // Asynchronous reset with three words queued
        do_reset("mid_rst0");
        inrequest[0] = 1'b1;
        datain[0 +: W] = $urandom;
        repeat (3) step(1, 100, 4'b0001);
        check("mid_count3", {61'd0, count}, 64'd3);
        do_reset("mid_rst");
        inrequest = 4'b1010;
        datain[W +: W] = $urandom;
        datain[3*W +: W] = $urandom;
        #1;
        check("mid_first_grant", {60'd0, incapable}, 64'h2);
        drain(20);

        // Accept with nothing queued
        outaccept = 1'b1;
        repeat (5) begin
            step(0, 0, '0);
            check("empty_outvalid", {63'd0, outvalid}, 64'd0);
            check("empty_count", {61'd0, count}, 64'd0);
        end
        outaccept = 1'b0;

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            outaccept = 1'($urandom_range(0, 1));
            step(1, 30, 4'hF);
        end
        drain(60);
        check("drain_queue", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
